// File: rtl/shift_add_multiplier_4bit_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier slice:
// FSM state encodings, operand and counter widths, and the last iteration index.
package shift_add_multiplier_4bit_pkg;

  localparam int OPW  = 4;
  localparam int CNTW = 2;

  localparam logic [CNTW-1:0] LAST_ITER = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : shift_add_multiplier_4bit_pkg

// File: rtl/shift_add_multiplier_4bit_adder.sv
// 4-bit ripple-carry adder shared by the multiplier datapath.
// The carry chain is spelled out bit by bit so every net has a single driver.
module ripple_carry_adder_4bit
  import shift_add_multiplier_4bit_pkg::*;
(
  input  logic [OPW-1:0] A,
  input  logic [OPW-1:0] B,
  input  logic           Cin,
  output logic [OPW-1:0] Sum,
  output logic           Cout
);

  logic c1_s;
  logic c2_s;
  logic c3_s;

  assign Sum[0] = A[0] ^ B[0] ^ Cin;
  assign c1_s   = (A[0] & B[0]) | (A[0] & Cin)  | (B[0] & Cin);
  assign Sum[1] = A[1] ^ B[1] ^ c1_s;
  assign c2_s   = (A[1] & B[1]) | (A[1] & c1_s) | (B[1] & c1_s);
  assign Sum[2] = A[2] ^ B[2] ^ c2_s;
  assign c3_s   = (A[2] & B[2]) | (A[2] & c2_s) | (B[2] & c2_s);
  assign Sum[3] = A[3] ^ B[3] ^ c3_s;
  assign Cout   = (A[3] & B[3]) | (A[3] & c3_s) | (B[3] & c3_s);

endmodule : ripple_carry_adder_4bit

// File: rtl/shift_add_multiplier_4bit.sv
// Sequential 4x4 unsigned multiplier: accepts A/B over a valid/ready
// handshake, performs one shift-and-add iteration per clock for four clocks,
// then holds the 8-bit product until the consumer takes it.
module shift_add_multiplier_4bit
  import shift_add_multiplier_4bit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] A,
  input  logic [OPW-1:0] B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     product,
  output logic           busy
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic [OPW-1:0]  m_q,     m_d;
  logic [OPW-1:0]  q_q,     q_d;
  logic [OPW-1:0]  acc_q,   acc_d;
  logic [7:0]      product_q, product_d;

  logic [OPW-1:0]  addend_s;
  logic [OPW-1:0]  sum_s;
  logic            cout_s;
  logic [7:0]      shifted_s;

  // Partial product is the multiplicand when the current multiplier LSB is set.
  assign addend_s = q_q[0] ? m_q : 4'b0000;

  ripple_carry_adder_4bit u_adder (
    .A    (acc_q),
    .B    (addend_s),
    .Cin  (1'b0),
    .Sum  (sum_s),
    .Cout (cout_s)
  );

  // The 9-bit {Cout, Sum, Q[3:1]} shifted right by one: carry lands in ACC[3].
  assign shifted_s = {cout_s, sum_s, q_q[3:1]};

  // Next-state and datapath update for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CALC;
          m_d     = A;
          q_d     = B;
          acc_d   = 4'b0000;
          cnt_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = shifted_s[7:4];
        q_d   = shifted_s[3:0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_ITER) begin
          state_d   = ST_DONE;
          product_d = shifted_s;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      m_q       <= 4'b0000;
      q_q       <= 4'b0000;
      acc_q     <= 4'b0000;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  // Handshake flags come straight from the state register, never from inputs.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign product   = product_q;

endmodule : shift_add_multiplier_4bit

// File: tb/tb_shift_add_multiplier_4bit.sv
// Directed self-checking bench for shift_add_multiplier_4bit.
module tb_shift_add_multiplier_4bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int vec_cnt;
  int err_cnt;
  int cyc;

  shift_add_multiplier_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 00",
               in_ready, out_valid, busy, product);
    end
  endtask

  task automatic test_basic();
    a = 4'd3; b = 4'd5; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL basic_calc%0d: busy=%b out_valid=%b in_ready=%b, want 1 0 0",
                 i, busy, out_valid, in_ready);
      end
      tick();
    end
    vec_cnt++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || product !== 8'h0F) begin
      err_cnt++;
      $display("FAIL basic_done: out_valid=%b busy=%b product=%h, want 1 0 0F",
               out_valid, busy, product);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_drain: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_carry();
    logic [3:0] ta [3];
    logic [3:0] tb [3];
    logic [7:0] te [3];
    int n;
    ta[0] = 4'd15; tb[0] = 4'd15; te[0] = 8'hE1;
    ta[1] = 4'd15; tb[1] = 4'd1;  te[1] = 8'h0F;
    ta[2] = 4'd0;  tb[2] = 4'd9;  te[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      a = ta[k]; b = tb[k]; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      vec_cnt++;
      if (n != 4 || product !== te[k]) begin
        err_cnt++;
        $display("FAIL carry%0d: %0d*%0d latency=%0d product=%h, want latency=4 product=%h",
                 k, ta[k], tb[k], n, product, te[k]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    a = 4'd9; b = 4'd11; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    a = 4'd2; b = 4'd2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 8'h63) begin
        err_cnt++;
        $display("FAIL backpressure%0d: out_valid=%b in_ready=%b product=%h, want 1 0 63",
                 i, out_valid, in_ready, product);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 8'h63) begin
      err_cnt++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 63",
               in_ready, out_valid, busy, product);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    a = 4'd13; b = 4'd11; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 00",
               in_ready, out_valid, busy, product);
    end
    a = 4'd6; b = 4'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n != 4 || product !== 8'h2A) begin
      err_cnt++;
      $display("FAIL reset_mid_recover: latency=%0d product=%h, want latency=4 product=2A", n, product);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int acc_cyc;
    int prev_cyc;
    logic [7:0] exp;
    prev_cyc = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = i[7:4];
      b = i[3:0];
      exp = {4'b0000, a} * {4'b0000, b};
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      acc_cyc = cyc;
      tick();
      n = 0;
      while (out_valid !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      vec_cnt++;
      if (n != 4 || product !== exp) begin
        err_cnt++;
        $display("FAIL exhaustive %0d*%0d: latency=%0d product=%h, want latency=4 product=%h",
                 a, b, n, product, exp);
      end
      if (prev_cyc >= 0) begin
        vec_cnt++;
        if (acc_cyc - prev_cyc != 6) begin
          err_cnt++;
          $display("FAIL spacing %0d*%0d: accept interval=%0d, want 6", a, b, acc_cyc - prev_cyc);
        end
      end
      prev_cyc = acc_cyc;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    cyc = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 4'd0;
    b = 4'd0;
    #2;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_shift_add_multiplier_4bit
